// File: rtl/axil_ctrl_master_pkg.sv
// Shared types for the AXI4-Lite control-port sequencer.
// Holds the command opcodes, the sequencer states and the AXI OKAY response code.
// Imported by the interface-facing top; it has no logic of its own.
package axil_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_WRITE = 2'd0,
    OP_READ  = 2'd1,
    OP_POLL  = 2'd2,
    OP_NOP   = 2'd3
  } cmd_op_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    WB   = 3'd2,
    RD   = 3'd3,
    RW   = 3'd4,
    GAP  = 3'd5,
    RSP  = 3'd6
  } state_e;

  localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/axil_ctrl_master_if.sv
// AXI4-Lite bus between the control sequencer and a kernel s_axi_control port.
// Pure wiring, no latency.
// Each channel carries its own valid/ready pair; the master modport drives valids.
interface axil_ctrl_master_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) ();

  logic                  awvalid;
  logic [ADDR_W-1:0]     awaddr;
  logic                  awready;
  logic                  wvalid;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   wstrb;
  logic                  wready;
  logic                  bvalid;
  logic [1:0]            bresp;
  logic                  bready;
  logic                  arvalid;
  logic [ADDR_W-1:0]     araddr;
  logic                  arready;
  logic                  rvalid;
  logic [DATA_W-1:0]     rdata;
  logic [1:0]            rresp;
  logic                  rready;

  modport master (
    output awvalid, awaddr, input awready,
    output wvalid, wdata, wstrb, input wready,
    input  bvalid, bresp, output bready,
    output arvalid, araddr, input arready,
    input  rvalid, rdata, rresp, output rready
  );

  modport slave (
    input  awvalid, awaddr, output awready,
    input  wvalid, wdata, wstrb, output wready,
    output bvalid, bresp, input bready,
    input  arvalid, araddr, output arready,
    output rvalid, rdata, rresp, input rready
  );

endinterface

// File: rtl/axil_ctrl_master.sv
// AXI4-Lite initiator executing WRITE / READ / POLL / NOP commands, one response each.
// Latency: accept cycle to rsp_valid cycle is 4 cycles inclusive against a zero-wait slave.
// One command in flight; cmd_ready only in IDLE; response held until rsp_ready.
module axil_ctrl_master
  import axil_ctrl_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int POLL_GAP = 16,
  parameter int POLL_MAX = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [DATA_W-1:0] cmd_mask,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [1:0]        rsp_resp,
  output logic              rsp_timeout,
  axil_ctrl_master_if.master m_axi_control
);

  localparam int STRB_W = DATA_W / 8;
  // Poll counter must still be legal when POLL_MAX is 0 (unbounded, counter unused).
  localparam int PCW = (POLL_MAX > 0) ? $clog2(POLL_MAX + 1) : 1;
  localparam int GW  = $clog2(POLL_GAP + 1);
  localparam logic [PCW:0]  POLL_LAST = (PCW + 1)'(POLL_MAX);
  localparam logic [PCW:0]  POLL_ONE  = (PCW + 1)'(1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(POLL_GAP - 1);

  state_e              state_q, state_d;
  cmd_op_e             op_q, op_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   mask_q, mask_d;
  logic                awvalid_q, awvalid_d;
  logic                wvalid_q, wvalid_d;
  logic                bready_q, bready_d;
  logic                arvalid_q, arvalid_d;
  logic                rready_q, rready_d;
  logic                aw_done_q, aw_done_d;
  logic                w_done_q, w_done_d;
  logic [GW-1:0]       gap_cnt_q, gap_cnt_d;
  logic [PCW-1:0]      poll_cnt_q, poll_cnt_d;
  logic                cmd_ready_d;
  logic                rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_d;
  logic [1:0]          rsp_resp_d;
  logic                rsp_timeout_d;

  logic aw_hs, w_hs, poll_hit, poll_last;

  assign aw_hs     = awvalid_q & m_axi_control.awready;
  assign w_hs      = wvalid_q & m_axi_control.wready;
  assign poll_hit  = ((m_axi_control.rdata ^ wdata_q) & mask_q) == '0;
  assign poll_last = (POLL_MAX != 0) && (({1'b0, poll_cnt_q} + POLL_ONE) == POLL_LAST);

  // Every AXI output comes straight from a flop; address/data hold for the whole command.
  assign m_axi_control.awvalid = awvalid_q;
  assign m_axi_control.awaddr  = addr_q;
  assign m_axi_control.wvalid  = wvalid_q;
  assign m_axi_control.wdata   = wdata_q;
  assign m_axi_control.wstrb   = mask_q[STRB_W-1:0];
  assign m_axi_control.bready  = bready_q;
  assign m_axi_control.arvalid = arvalid_q;
  assign m_axi_control.araddr  = addr_q;
  assign m_axi_control.rready  = rready_q;

  // Next-state and next-output decode; registered outputs are computed one cycle ahead.
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    mask_d        = mask_q;
    awvalid_d     = awvalid_q;
    wvalid_d      = wvalid_q;
    bready_d      = bready_q;
    arvalid_d     = arvalid_q;
    rready_d      = rready_q;
    aw_done_d     = aw_done_q;
    w_done_d      = w_done_q;
    gap_cnt_d     = gap_cnt_q;
    poll_cnt_d    = poll_cnt_q;
    rsp_valid_d   = rsp_valid;
    rsp_rdata_d   = rsp_rdata;
    rsp_resp_d    = rsp_resp;
    rsp_timeout_d = rsp_timeout;

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          op_d       = cmd_op_e'(cmd_op);
          addr_d     = cmd_addr;
          wdata_d    = cmd_wdata;
          mask_d     = cmd_mask;
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
          poll_cnt_d = '0;
          case (cmd_op_e'(cmd_op))
            OP_WRITE: begin
              state_d   = WR;
              awvalid_d = 1'b1;
              wvalid_d  = 1'b1;
            end
            OP_READ, OP_POLL: begin
              state_d   = RD;
              arvalid_d = 1'b1;
            end
            default: begin
              state_d       = RSP;
              rsp_valid_d   = 1'b1;
              rsp_rdata_d   = '0;
              rsp_resp_d    = RESP_OKAY;
              rsp_timeout_d = 1'b0;
            end
          endcase
        end
      end
      WR: begin
        // AW and W finish independently; wait for both before taking B.
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
          state_d  = WB;
          bready_d = 1'b1;
        end
      end
      WB: begin
        if (m_axi_control.bvalid) begin
          bready_d      = 1'b0;
          state_d       = RSP;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = '0;
          rsp_resp_d    = m_axi_control.bresp;
          rsp_timeout_d = 1'b0;
        end
      end
      RD: begin
        if (m_axi_control.arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RW;
        end
      end
      RW: begin
        if (m_axi_control.rvalid) begin
          rready_d    = 1'b0;
          rsp_rdata_d = m_axi_control.rdata;
          rsp_resp_d  = m_axi_control.rresp;
          // Error responses end a poll immediately and are never retried.
          if (op_q == OP_READ || poll_hit || m_axi_control.rresp != RESP_OKAY) begin
            state_d       = RSP;
            rsp_valid_d   = 1'b1;
            rsp_timeout_d = 1'b0;
          end else if (poll_last) begin
            state_d       = RSP;
            rsp_valid_d   = 1'b1;
            rsp_timeout_d = 1'b1;
          end else begin
            state_d    = GAP;
            gap_cnt_d  = '0;
            poll_cnt_d = poll_cnt_q + PCW'(1);
          end
        end
      end
      GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d   = RD;
          arvalid_d = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end
      RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    cmd_ready_d = (state_d == IDLE);
  end

  // State and output register bank; reset abandons any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      op_q        <= OP_WRITE;
      addr_q      <= '0;
      wdata_q     <= '0;
      mask_q      <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      gap_cnt_q   <= '0;
      poll_cnt_q  <= '0;
      cmd_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_resp    <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      mask_q      <= mask_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      gap_cnt_q   <= gap_cnt_d;
      poll_cnt_q  <= poll_cnt_d;
      cmd_ready   <= cmd_ready_d;
      rsp_valid   <= rsp_valid_d;
      rsp_rdata   <= rsp_rdata_d;
      rsp_resp    <= rsp_resp_d;
      rsp_timeout <= rsp_timeout_d;
    end
  end

endmodule
